// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // Highest value a digit may hold before wrapping on a borrow.
    localparam logic [3:0] DIGIT_MAX_UNITS = 4'd9;
    localparam logic [3:0] DIGIT_MAX_TENS  = 4'd5;

    // "+30 s" as a two-digit BCD seconds value.
    localparam logic [7:0] ADD30_BCD = 8'h30;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the timer: parallel load, or decrement with borrow chaining
// (wraps 0 -> LIMIT when borrowing).
module bcd_digit
    import timer_pkg::*;
#(
    parameter logic [3:0] LIMIT = DIGIT_MAX_UNITS
) (
    input  logic       CLK,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    input  logic       borrow_in,
    output logic [3:0] value,
    output logic       borrow_out,
    output logic       is_zero
);

    assign is_zero    = (value == 4'd0);
    assign borrow_out = borrow_in & is_zero;

    always_ff @(posedge CLK or posedge clear) begin
        if (clear) begin
            value <= 4'd0;
        end else if (load) begin
            value <= load_val;
        end else if (dec && borrow_in) begin
            value <= is_zero ? LIMIT : value - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Keypad-loaded mm:ss BCD countdown timer with IDLE/RUN/PAUSE control.
// Optional "+30 s" button enabled by defining TIMER_ADD30_EN.
module bcd_countdown_timer
    import timer_pkg::*;
#(
    parameter int MIN_DIGITS = 2
) (
    input  logic                        CLK,
    input  logic                        clear,
    input  logic                        tick,
    input  logic                        key_valid,
    input  logic [3:0]                  key_digit,
    input  logic                        start,
    input  logic                        stop,
`ifdef TIMER_ADD30_EN
    input  logic                        add30,
`endif
    output logic [4*(MIN_DIGITS+2)-1:0] time_bcd,
    output logic                        running,
    output logic                        paused,
    output logic                        done,
    output logic                        key_err
);

    localparam int N = MIN_DIGITS + 2;
    localparam int W = 4 * N;

    state_t         state, state_next;
    logic           dig_load;
    logic [W-1:0]   load_val;
    logic           dec_en;
    logic           done_next;
    logic           key_err_next;
    logic [N:0]     chain;
    logic [N-1:0]   zero_flag;
    logic           time_zero;
    logic           time_one;

`ifdef TIMER_ADD30_EN
    // Adds 30 s in BCD; a carry out of the top minute digit saturates to max.
    function automatic logic [W-1:0] add30_sat(input logic [W-1:0] t);
        logic [W-1:0] r;
        logic [3:0]   d;
        logic         carry;
        r = t;
        d = t[7:4] + ADD30_BCD[7:4];
        if (d > DIGIT_MAX_TENS) begin
            r[7:4] = d - 4'd6;
            carry  = 1'b1;
        end else begin
            r[7:4] = d;
            carry  = 1'b0;
        end
        for (int i = 2; i < N; i++) begin
            d = t[4*i +: 4] + {3'b000, carry};
            if (d > DIGIT_MAX_UNITS) begin
                r[4*i +: 4] = 4'd0;
                carry       = 1'b1;
            end else begin
                r[4*i +: 4] = d;
                carry       = 1'b0;
            end
        end
        if (carry) begin
            for (int i = 0; i < N; i++) begin
                r[4*i +: 4] = (i == 1) ? DIGIT_MAX_TENS : DIGIT_MAX_UNITS;
            end
        end
        return r;
    endfunction
`endif

    assign chain[0] = 1'b1;

    for (genvar i = 0; i < N; i++) begin : g_digit
        bcd_digit #(
            .LIMIT((i == 1) ? DIGIT_MAX_TENS : DIGIT_MAX_UNITS)
        ) u_digit (
            .CLK       (CLK),
            .clear     (clear),
            .load      (dig_load),
            .load_val  (load_val[4*i +: 4]),
            .dec       (dec_en),
            .borrow_in (chain[i]),
            .value     (time_bcd[4*i +: 4]),
            .borrow_out(chain[i+1]),
            .is_zero   (zero_flag[i])
        );
    end

    assign time_zero = &zero_flag;
    assign time_one  = (time_bcd[3:0] == 4'd1) && (&zero_flag[N-1:1]);

    // A request that means nothing in the current state is treated as absent,
    // so it never masks a lower-priority request.
    always_comb begin
        state_next   = state;
        dig_load     = 1'b0;
        load_val     = time_bcd;
        dec_en       = 1'b0;
        done_next    = 1'b0;
        key_err_next = 1'b0;
        case (state)
            ST_IDLE: begin
                if (stop) begin
                    dig_load = 1'b1;
                    load_val = '0;
                end else if (start && !time_zero) begin
                    state_next = ST_RUN;
                end
`ifdef TIMER_ADD30_EN
                else if (add30) begin
                    dig_load = 1'b1;
                    load_val = add30_sat(time_bcd);
                    if (time_zero) begin
                        state_next = ST_RUN;
                    end
                end
`endif
                else if (key_valid) begin
                    if (key_digit > DIGIT_MAX_UNITS || time_bcd[3:0] > DIGIT_MAX_TENS) begin
                        key_err_next = 1'b1;
                    end else begin
                        dig_load = 1'b1;
                        load_val = {time_bcd[W-5:0], key_digit};
                    end
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_next = ST_PAUSE;
                end
`ifdef TIMER_ADD30_EN
                else if (add30) begin
                    dig_load = 1'b1;
                    load_val = add30_sat(time_bcd);
                end
`endif
                else if (tick) begin
                    dec_en = ~chain[N];
                    if (time_one) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    state_next = ST_IDLE;
                    dig_load   = 1'b1;
                    load_val   = '0;
                end else if (start) begin
                    state_next = ST_RUN;
                end
`ifdef TIMER_ADD30_EN
                else if (add30) begin
                    dig_load = 1'b1;
                    load_val = add30_sat(time_bcd);
                end
`endif
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge clear) begin
        if (clear) begin
            state   <= ST_IDLE;
            running <= 1'b0;
            paused  <= 1'b0;
            done    <= 1'b0;
            key_err <= 1'b0;
        end else begin
            state   <= state_next;
            running <= (state_next == ST_RUN);
            paused  <= (state_next == ST_PAUSE);
            done    <= done_next;
            key_err <= key_err_next;
        end
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: directed scenarios plus random stimulus against
// a seconds-based reference model. Define TIMER_ADD30_EN to cover "+30 s".
module tb_bcd_countdown_timer;

    localparam int MIN_DIGITS = 2;
    localparam int N = MIN_DIGITS + 2;
    localparam int W = 4 * N;
`ifdef TIMER_ADD30_EN
    localparam bit ADD_EN = 1'b1;
`else
    localparam bit ADD_EN = 1'b0;
`endif
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;

    logic         CLK = 1'b0;
    logic         clear;
    logic         tick;
    logic         key_valid;
    logic [3:0]   key_digit;
    logic         start;
    logic         stop;
`ifdef TIMER_ADD30_EN
    logic         add30;
`endif
    logic [W-1:0] time_bcd;
    logic         running;
    logic         paused;
    logic         done;
    logic         key_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: displayed value as a plain decimal number (e.g. 130 = 01:30).
    int mdl_val;
    int mdl_mode;
    bit mdl_done;
    bit mdl_err;
    int mod_val;
    int max_sec;

    always #5 CLK = ~CLK;

    bcd_countdown_timer #(.MIN_DIGITS(MIN_DIGITS)) dut (
        .CLK      (CLK),
        .clear    (clear),
        .tick     (tick),
        .key_valid(key_valid),
        .key_digit(key_digit),
        .start    (start),
        .stop     (stop),
`ifdef TIMER_ADD30_EN
        .add30    (add30),
`endif
        .time_bcd (time_bcd),
        .running  (running),
        .paused   (paused),
        .done     (done),
        .key_err  (key_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int to_sec(input int d);
        return (d / 100) * 60 + (d % 100);
    endfunction

    function automatic int from_sec(input int s);
        return (s / 60) * 100 + (s % 60);
    endfunction

    function automatic logic [W-1:0] to_bcd(input int d);
        logic [W-1:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < N; i++) begin
            r[4*i +: 4] = 4'((d / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic model_add30();
        int s;
        s = to_sec(mdl_val) + 30;
        if (s > max_sec) s = max_sec;
        mdl_val = from_sec(s);
    endtask

    task automatic model_step(input bit t, input bit kv, input int kd,
                              input bit st, input bit sp, input bit a30);
        mdl_done = 1'b0;
        mdl_err  = 1'b0;
        case (mdl_mode)
            M_IDLE: begin
                if (sp) mdl_val = 0;
                else if (st && mdl_val != 0) mdl_mode = M_RUN;
                else if (a30) begin
                    if (mdl_val == 0) mdl_mode = M_RUN;
                    model_add30();
                end else if (kv) begin
                    if (kd > 9 || (mdl_val % 10) > 5) mdl_err = 1'b1;
                    else mdl_val = (mdl_val * 10 + kd) % mod_val;
                end
            end
            M_RUN: begin
                if (sp) mdl_mode = M_PAUSE;
                else if (a30) model_add30();
                else if (t) begin
                    mdl_val = from_sec(to_sec(mdl_val) - 1);
                    if (mdl_val == 0) begin
                        mdl_mode = M_IDLE;
                        mdl_done = 1'b1;
                    end
                end
            end
            default: begin
                if (sp) begin
                    mdl_val  = 0;
                    mdl_mode = M_IDLE;
                end else if (st) mdl_mode = M_RUN;
                else if (a30) model_add30();
            end
        endcase
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".time"},    32'(time_bcd), 32'(to_bcd(mdl_val)));
        check({tag, ".running"}, 32'(running),  32'(mdl_mode == M_RUN));
        check({tag, ".paused"},  32'(paused),   32'(mdl_mode == M_PAUSE));
        check({tag, ".done"},    32'(done),     32'(mdl_done));
        check({tag, ".key_err"}, 32'(key_err),  32'(mdl_err));
    endtask

    task automatic cycle(input string tag, input bit t, input bit kv, input logic [3:0] kd,
                         input bit st, input bit sp, input bit a30);
        tick      = t;
        key_valid = kv;
        key_digit = kd;
        start     = st;
        stop      = sp;
`ifdef TIMER_ADD30_EN
        add30     = a30;
`endif
        model_step(t, kv, int'(kd), st, sp, a30 && ADD_EN);
        @(posedge CLK);
        #1;
        check_outputs(tag);
        tick      = 1'b0;
        key_valid = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
`ifdef TIMER_ADD30_EN
        add30     = 1'b0;
`endif
    endtask

    task automatic key(input logic [3:0] d);
        cycle("key", 1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cycle("tick", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_start();
        cycle("start", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_stop();
        cycle("stop", 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic flush();
        do_stop();
        do_stop();
    endtask

    task automatic do_clear(input string tag);
        #1 clear = 1'b1;
        #1;
        mdl_val  = 0;
        mdl_mode = M_IDLE;
        mdl_done = 1'b0;
        mdl_err  = 1'b0;
        check_outputs(tag);
        #1 clear = 1'b0;
    endtask

    initial begin
        mod_val = 1;
        for (int i = 0; i < N; i++) mod_val = mod_val * 10;
        max_sec = (mod_val / 100 - 1) * 60 + 59;
        mdl_val = 0;
        mdl_mode = M_IDLE;
        mdl_done = 1'b0;
        mdl_err = 1'b0;
        clear = 1'b1;
        tick = 1'b0;
        key_valid = 1'b0;
        key_digit = 4'd0;
        start = 1'b0;
        stop = 1'b0;
`ifdef TIMER_ADD30_EN
        add30 = 1'b0;
`endif
        @(posedge CLK);
        #1;
        check_outputs("reset");
        clear = 1'b0;

        // Load 01:30, run it out.
        key(4'd1); key(4'd3); key(4'd0);
        check("load_0130", 32'(time_bcd), 32'h0130);
        do_start();
        ticks(90);
        check("count_zero", 32'(time_bcd), 32'h0000);
        check("count_done", 32'(done), 32'd1);
        ticks(1);

        // Tens-of-seconds digit would exceed 5.
        key(4'd7); key(4'd8);
        check("reject_err", 32'(key_err), 32'd1);
        check("reject_hold", 32'(time_bcd), 32'h0007);
        key(4'd11);
        flush();

        // Full borrow chain.
        key(4'd1); key(4'd0); key(4'd0); key(4'd0);
        do_start();
        ticks(1);
        check("borrow_chain", 32'(time_bcd), 32'h0959);
        flush();

        // Pause with coincident tick, resume, finish; then cancel from pause.
        key(4'd5); do_start();
        cycle("stop_tick", 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        check("pause_hold", 32'(time_bcd), 32'h0005);
        do_start();
        ticks(5);
        check("resume_done", 32'(done), 32'd1);
        key(4'd5); do_start(); do_stop(); do_stop();
        check("cancel_clear", 32'(time_bcd), 32'h0000);

`ifdef TIMER_ADD30_EN
        key(4'd4); key(4'd5); do_start();
        cycle("add30_run", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        check("add30_carry", 32'(time_bcd), 32'h0115);
        flush();
        key(4'd9); key(4'd9); key(4'd4); key(4'd5);
        cycle("add30_sat", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        check("add30_sat", 32'(time_bcd), 32'h9959);
        flush();
        cycle("add30_quick", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        check("quick_start", 32'(time_bcd), 32'h0030);
        check("quick_run", 32'(running), 32'd1);
        flush();
`endif

        // Asynchronous clear mid-run.
        key(4'd1); key(4'd2); do_start();
        do_clear("clear_run");
        check("clear_time", 32'(time_bcd), 32'h0000);
        ticks(3);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 350) do_clear("rand_clear");
            cycle("rand", ($urandom % 3) == 0, ($urandom % 3) == 0, 4'($urandom_range(0, 11)),
                  ($urandom % 8) == 0, ($urandom % 30) == 0, ($urandom % 25) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
